// File: rtl/tdm_pkg.sv
// ============================================================================
// Module  : tdm_pkg
// Purpose : Shared types and defaults for the 2:1 TDM receive path.
// Rev     : 1.0
// ============================================================================
`default_nettype none

package tdm_pkg;

    typedef enum logic [0:0] {
        HUNT = 1'b0,
        RUN  = 1'b1
    } tdm_state_t;

    localparam int TDM_WIDTH = 2;

endpackage : tdm_pkg

`default_nettype wire

// File: rtl/tdm_slot_counter.sv
// ============================================================================
// Module  : tdm_slot_counter
// Purpose : Slot index counter; restart forces slot 1, advance wraps at the last slot.
// Rev     : 1.0
// ============================================================================
`default_nettype none

module tdm_slot_counter
    import tdm_pkg::*;
#(
    parameter int WIDTH = TDM_WIDTH,
    parameter int SEL_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_restart,
    input  logic             i_advance,
    output logic [SEL_W-1:0] o_cnt,
    output logic             o_last
);

    localparam logic [SEL_W-1:0] c_LAST = SEL_W'(WIDTH - 1);
    localparam logic [SEL_W-1:0] c_ONE  = SEL_W'(1);
    localparam logic [SEL_W-1:0] c_ZERO = '0;

    logic [SEL_W-1:0] r_cnt;
    logic             w_last;

    assign w_last = (r_cnt == c_LAST);

    // Restart wins: the beat that carries sync is always slot 0, so the next one is slot 1.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= c_ZERO;
        end else if (i_restart) begin
            r_cnt <= c_ONE;
        end else if (i_advance) begin
            r_cnt <= w_last ? c_ZERO : (r_cnt + c_ONE);
        end
    end

    assign o_cnt  = r_cnt;
    assign o_last = w_last;

endmodule : tdm_slot_counter

`default_nettype wire

// File: rtl/tdm_demux21.sv
// ============================================================================
// Module  : tdm_demux21
// Purpose : Reassembles a serial TDM stream into parallel words with framing check.
// Rev     : 1.0
// ============================================================================
`default_nettype none

module tdm_demux21
    import tdm_pkg::*;
#(
    parameter int WIDTH = TDM_WIDTH,
    parameter int SEL_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             din,
    input  logic             din_valid,
    input  logic             sync,
    output logic [WIDTH-1:0] q,
    output logic             q_valid,
    output logic [SEL_W-1:0] select,
    output logic             frame_err
);

    tdm_state_t       r_state;
    tdm_state_t       w_state_nxt;

    logic [WIDTH-1:0] r_acc;
    logic [WIDTH-1:0] r_q;
    logic             r_q_valid;
    logic             r_frame_err;

    logic [SEL_W-1:0] w_cnt;
    logic             w_last;
    logic             w_restart;
    logic             w_advance;
    logic             w_load;
    logic             w_frame_err;
    logic [WIDTH-1:0] w_acc_nxt;

    tdm_slot_counter #(
        .WIDTH (WIDTH),
        .SEL_W (SEL_W)
    ) u_slot_counter (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_restart (w_restart),
        .i_advance (w_advance),
        .o_cnt     (w_cnt),
        .o_last    (w_last)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= HUNT;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            HUNT: begin
                if (din_valid && sync) begin
                    w_state_nxt = RUN;
                end
            end
            RUN: begin
                if (din_valid && !sync && w_last) begin
                    w_state_nxt = HUNT;
                end
            end
            default: w_state_nxt = HUNT;
        endcase
    end

    // Sync on any beat starts a new frame; in RUN that means the previous one was cut short.
    always_comb begin
        w_restart   = din_valid && sync;
        w_advance   = din_valid && !sync && (r_state == RUN);
        w_frame_err = din_valid && sync && (r_state == RUN);
        w_load      = w_advance && w_last;
        w_acc_nxt   = r_acc;
        if (w_restart) begin
            w_acc_nxt[0] = din;
        end else if (w_advance) begin
            for (int k = 0; k < WIDTH; k++) begin
                if (w_cnt == SEL_W'(k)) begin
                    w_acc_nxt[k] = din;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_acc       <= '0;
            r_q         <= '0;
            r_q_valid   <= 1'b0;
            r_frame_err <= 1'b0;
        end else begin
            r_acc       <= w_acc_nxt;
            r_q_valid   <= w_load;
            r_frame_err <= w_frame_err;
            if (w_load) begin
                r_q <= {din, r_acc[WIDTH-2:0]};
            end
        end
    end

    assign q         = r_q;
    assign q_valid   = r_q_valid;
    assign frame_err = r_frame_err;
    assign select    = w_cnt;

endmodule : tdm_demux21

`default_nettype wire

// File: tb/tb_tdm_demux21.sv
// ============================================================================
// Module  : tb_tdm_demux21
// Purpose : Directed self-checking bench for tdm_demux21 at WIDTH=2.
// Rev     : 1.0
// ============================================================================
`default_nettype none

module tb_tdm_demux21;

    logic       clk;
    logic       rst_n;
    logic       din;
    logic       din_valid;
    logic       sync;
    logic [1:0] q;
    logic       q_valid;
    logic [0:0] select;
    logic       frame_err;

    int n_checks;
    int n_errors;

    // Observation vector: {q[1:0], q_valid, frame_err, select}
    logic [4:0] obs;
    assign obs = {q, q_valid, frame_err, select};

    tdm_demux21 #(
        .WIDTH (2)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .din       (din),
        .din_valid (din_valid),
        .sync      (sync),
        .q         (q),
        .q_valid   (q_valid),
        .select    (select),
        .frame_err (frame_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step(input logic v, input logic s, input logic d);
        din_valid = v;
        sync      = s;
        din       = d;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step(i[0], 1'b1, 1'b1);
            n_checks++;
            if (obs !== 5'b00_0_0_0) begin
                n_errors++;
                $display("FAIL reset_hold cyc%0d got=%b exp=%b", i, obs, 5'b00_0_0_0);
            end
        end
        din_valid = 1'b0;
        sync      = 1'b0;
        #2 rst_n  = 1'b1;
        for (int i = 0; i < 2; i++) begin
            step(1'b0, 1'b0, 1'b0);
            n_checks++;
            if (obs !== 5'b00_0_0_0) begin
                n_errors++;
                $display("FAIL reset_release cyc%0d got=%b exp=%b", i, obs, 5'b00_0_0_0);
            end
        end
    endtask

    task automatic test_basic();
        logic [4:0] exp [6];
        exp = '{5'b00_0_0_1, 5'b11_1_0_0, 5'b11_0_0_0, 5'b11_0_0_1, 5'b10_1_0_0, 5'b10_0_0_0};
        step(1'b1, 1'b1, 1'b1);
        n_checks++;
        if (obs !== exp[0]) begin n_errors++; $display("FAIL basic_s0a got=%b exp=%b", obs, exp[0]); end
        step(1'b1, 1'b0, 1'b1);
        n_checks++;
        if (obs !== exp[1]) begin n_errors++; $display("FAIL basic_s1a got=%b exp=%b", obs, exp[1]); end
        step(1'b0, 1'b0, 1'b0);
        n_checks++;
        if (obs !== exp[2]) begin n_errors++; $display("FAIL basic_idle got=%b exp=%b", obs, exp[2]); end
        step(1'b1, 1'b1, 1'b0);
        n_checks++;
        if (obs !== exp[3]) begin n_errors++; $display("FAIL basic_s0b got=%b exp=%b", obs, exp[3]); end
        step(1'b1, 1'b0, 1'b1);
        n_checks++;
        if (obs !== exp[4]) begin n_errors++; $display("FAIL basic_s1b got=%b exp=%b", obs, exp[4]); end
        step(1'b0, 1'b0, 1'b0);
        n_checks++;
        if (obs !== exp[5]) begin n_errors++; $display("FAIL basic_hold got=%b exp=%b", obs, exp[5]); end
    endtask

    task automatic test_gaps();
        step(1'b1, 1'b1, 1'b1);
        n_checks++;
        if (obs !== 5'b10_0_0_1) begin n_errors++; $display("FAIL gap_s0 got=%b exp=%b", obs, 5'b10_0_0_1); end
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 1'b1, 1'b0);
            n_checks++;
            if (obs !== 5'b10_0_0_1) begin
                n_errors++;
                $display("FAIL gap_idle%0d got=%b exp=%b", i, obs, 5'b10_0_0_1);
            end
        end
        step(1'b1, 1'b0, 1'b0);
        n_checks++;
        if (obs !== 5'b01_1_0_0) begin n_errors++; $display("FAIL gap_s1 got=%b exp=%b", obs, 5'b01_1_0_0); end
        step(1'b0, 1'b0, 1'b0);
        n_checks++;
        if (obs !== 5'b01_0_0_0) begin n_errors++; $display("FAIL gap_after got=%b exp=%b", obs, 5'b01_0_0_0); end
    endtask

    task automatic test_early_sync();
        step(1'b1, 1'b1, 1'b1);
        n_checks++;
        if (obs !== 5'b01_0_0_1) begin n_errors++; $display("FAIL early_s0 got=%b exp=%b", obs, 5'b01_0_0_1); end
        step(1'b1, 1'b1, 1'b0);
        n_checks++;
        if (obs !== 5'b01_0_1_1) begin n_errors++; $display("FAIL early_err got=%b exp=%b", obs, 5'b01_0_1_1); end
        step(1'b1, 1'b0, 1'b1);
        n_checks++;
        if (obs !== 5'b10_1_0_0) begin n_errors++; $display("FAIL early_done got=%b exp=%b", obs, 5'b10_1_0_0); end
    endtask

    task automatic test_hunt_discard();
        #1 rst_n = 1'b0;
        #2 rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 1'b0, i[0]);
            n_checks++;
            if (obs !== 5'b00_0_0_0) begin
                n_errors++;
                $display("FAIL hunt_discard%0d got=%b exp=%b", i, obs, 5'b00_0_0_0);
            end
        end
        step(1'b1, 1'b1, 1'b1);
        n_checks++;
        if (obs !== 5'b00_0_0_1) begin n_errors++; $display("FAIL hunt_s0 got=%b exp=%b", obs, 5'b00_0_0_1); end
        step(1'b1, 1'b0, 1'b0);
        n_checks++;
        if (obs !== 5'b01_1_0_0) begin n_errors++; $display("FAIL hunt_s1 got=%b exp=%b", obs, 5'b01_1_0_0); end
    endtask

    task automatic test_back_to_back();
        logic [1:0] frames [4];
        logic [1:0] prev_q;
        frames = '{2'b11, 2'b10, 2'b01, 2'b00};
        prev_q = 2'b01;
        for (int i = 0; i < 4; i++) begin
            logic [1:0] f;
            f = frames[i];
            step(1'b1, 1'b1, f[0]);
            n_checks++;
            if (obs !== {prev_q, 3'b001}) begin
                n_errors++;
                $display("FAIL b2b_s0 frame%0d got=%b exp=%b", i, obs, {prev_q, 3'b001});
            end
            step(1'b1, 1'b0, f[1]);
            n_checks++;
            if (obs !== {f, 3'b100}) begin
                n_errors++;
                $display("FAIL b2b_s1 frame%0d got=%b exp=%b", i, obs, {f, 3'b100});
            end
            prev_q = f;
        end
    endtask

    task automatic test_reset_midframe();
        step(1'b1, 1'b1, 1'b1);
        step(1'b1, 1'b0, 1'b1);
        n_checks++;
        if (obs !== 5'b11_1_0_0) begin n_errors++; $display("FAIL mid_setup got=%b exp=%b", obs, 5'b11_1_0_0); end
        step(1'b1, 1'b1, 1'b1);
        n_checks++;
        if (obs !== 5'b11_0_0_1) begin n_errors++; $display("FAIL mid_s0 got=%b exp=%b", obs, 5'b11_0_0_1); end
        din_valid = 1'b1;
        sync      = 1'b0;
        din       = 1'b1;
        rst_n     = 1'b0;
        #1;
        n_checks++;
        if (obs !== 5'b00_0_0_0) begin n_errors++; $display("FAIL mid_async got=%b exp=%b", obs, 5'b00_0_0_0); end
        @(posedge clk);
        #1;
        n_checks++;
        if (obs !== 5'b00_0_0_0) begin n_errors++; $display("FAIL mid_edge got=%b exp=%b", obs, 5'b00_0_0_0); end
        rst_n = 1'b1;
        step(1'b1, 1'b0, 1'b1);
        n_checks++;
        if (obs !== 5'b00_0_0_0) begin n_errors++; $display("FAIL mid_after got=%b exp=%b", obs, 5'b00_0_0_0); end
    endtask

    initial begin
        n_checks  = 0;
        n_errors  = 0;
        rst_n     = 1'b0;
        din       = 1'b0;
        din_valid = 1'b0;
        sync      = 1'b0;
        #1;
        test_reset();
        test_basic();
        test_gaps();
        test_early_sync();
        test_hunt_discard();
        test_back_to_back();
        test_reset_midframe();
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule : tb_tdm_demux21

`default_nettype wire
